// File: rtl/product_accumulator_if.sv
// Beat-in / frame-out valid-ready bundle for product_accumulator.
interface product_accumulator_if #(
  parameter int N_STAGE = 5,
  parameter int ACC_W   = 12,
  parameter int BEATS_W = 4
);
  localparam int L = 1 << N_STAGE;

  logic               in_valid;
  logic               in_ready;
  logic [2*L-1:0]     mult_in;
  logic [BEATS_W-1:0] n_beats;
  logic [ACC_W-1:0]   threshold;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   acc_out;
  logic               spike;

  modport master (
    output in_valid, mult_in, n_beats,
    output threshold, out_ready,
    input  in_ready, out_valid,
    input  acc_out, spike
  );

  modport slave (
    input  in_valid, mult_in, n_beats,
    input  threshold, out_ready,
    output in_ready, out_valid,
    output acc_out, spike
  );
endinterface

// File: rtl/product_accumulator.sv
// Frame accumulator for packed 2-bit lane products with spike decision.
// Define ACC_SAT_EN to saturate the accumulator instead of wrapping.
module product_accumulator #(
  parameter int N_STAGE = 5,
  parameter int ACC_W   = 12,
  parameter int BEATS_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  product_accumulator_if.slave bus,
  output logic busy
);

  localparam int L     = 1 << N_STAGE;
  localparam int SUM_W = N_STAGE + 2;

  if (ACC_W < SUM_W) begin : g_bad_acc_w
    $error("ACC_W must be at least N_STAGE+2");
  end

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [BEATS_W-1:0] cnt_q, cnt_d;
  logic [BEATS_W-1:0] nb_q, nb_d;
  logic [ACC_W-1:0]   thr_q, thr_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic               sum_vld_q, sum_vld_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ov_q, ov_d;
  logic [ACC_W-1:0]   acc_out_q, acc_out_d;
  logic               spike_q, spike_d;

  logic [SUM_W-1:0]   lane_sum;
  logic [ACC_W-1:0]   acc_add;
  logic [BEATS_W-1:0] nb_eff;
  logic               first;
  logic               accept;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < L; i++) begin
      lane_sum = lane_sum + SUM_W'(bus.mult_in[2*i +: 2]);
    end
  end

`ifdef ACC_SAT_EN
  logic [ACC_W:0] acc_wide;
  assign acc_wide = {1'b0, acc_q} + (ACC_W+1)'(sum_q);
  assign acc_add  = acc_wide[ACC_W] ? '1 : acc_wide[ACC_W-1:0];
`else
  assign acc_add = acc_q + ACC_W'(sum_q);
`endif

  // The first beat compares against the live n_beats it is latching.
  assign first  = (cnt_q == '0);
  assign nb_eff = first ? bus.n_beats : nb_q;
  assign accept = bus.in_valid && (state_q == ACC);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    nb_d      = nb_q;
    thr_d     = thr_q;
    sum_d     = sum_q;
    sum_vld_d = 1'b0;
    acc_d     = acc_q;
    ov_d      = ov_q;
    acc_out_d = acc_out_q;
    spike_d   = spike_q;

    if (sum_vld_q) acc_d = acc_add;

    unique case (state_q)
      ACC: begin
        if (accept) begin
          sum_d     = lane_sum;
          sum_vld_d = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (first) begin
            nb_d  = bus.n_beats;
            thr_d = bus.threshold;
          end
          if (cnt_q == nb_eff) state_d = DRAIN;
        end
      end
      DRAIN: state_d = OUT;
      OUT: begin
        if (!ov_q) begin
          ov_d      = 1'b1;
          acc_out_d = acc_q;
          spike_d   = (acc_q >= thr_q);
        end else if (bus.out_ready) begin
          ov_d    = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACC;
      cnt_q     <= '0;
      nb_q      <= '0;
      thr_q     <= '0;
      sum_q     <= '0;
      sum_vld_q <= 1'b0;
      acc_q     <= '0;
      ov_q      <= 1'b0;
      acc_out_q <= '0;
      spike_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      nb_q      <= nb_d;
      thr_q     <= thr_d;
      sum_q     <= sum_d;
      sum_vld_q <= sum_vld_d;
      acc_q     <= acc_d;
      ov_q      <= ov_d;
      acc_out_q <= acc_out_d;
      spike_q   <= spike_d;
    end
  end

  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_valid = ov_q;
  assign bus.acc_out   = acc_out_q;
  assign bus.spike     = spike_q;
  assign busy          = (state_q != ACC) || (cnt_q != '0);

endmodule
